// File: rtl/matrix_seq.sv
// Multi-cycle sequencer for the 4-line x 32-bit matrix register file: MLOAD4,
// MSTORE4 and MOPA block operations, holding decode stalled until retire.
module matrix_seq #(
  parameter int unsigned MOPA_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_base,
  output logic        op_ready,
  output logic        busy_stall,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  r_matrix_index,
  input  logic [31:0] r_matrix_line,
  output logic        w_matrix_en,
  output logic [1:0]  w_matrix_index,
  output logic [31:0] w_matrix_data,
  output logic        mopa_start,
  output logic        w_matrix_en_mopa
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_REQ   = 3'd1,
    LD_WAIT  = 3'd2,
    ST_REQ   = 3'd3,
    MOPA_RUN = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_MOPA  = 2'b11;

  // Counter preload so that the commit lands MOPA_LAT cycles after mopa_start.
  localparam logic [3:0] MOPA_INIT = 4'(MOPA_LAT - 1);

  state_t      state_r;
  logic [1:0]  row_r;
  logic [3:0]  cnt_r;
  logic [31:0] base_r;
  logic [1:0]  code_r;

  logic        accept_s;
  logic        last_row_s;
  logic [31:0] addr_s;

  // Accept decode, last-row flag and line address (wraps modulo 2^32).
  always_comb begin
    accept_s   = (state_r == IDLE) && op_valid && (op_code != OP_NONE);
    last_row_s = (row_r == 2'd3);
    addr_s     = base_r + {28'd0, row_r, 2'b00};
  end

  // Sequencer state, row/MOPA counters and latched operation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      row_r   <= 2'd0;
      cnt_r   <= 4'd0;
      base_r  <= 32'd0;
      code_r  <= OP_NONE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            base_r <= op_base;
            code_r <= op_code;
            row_r  <= 2'd0;
            case (op_code)
              OP_LOAD:  state_r <= LD_REQ;
              OP_STORE: state_r <= ST_REQ;
              OP_MOPA: begin
                state_r <= MOPA_RUN;
                cnt_r   <= MOPA_INIT;
              end
              default:  state_r <= IDLE;
            endcase
          end
        end
        LD_REQ: begin
          if (mem_gnt) begin
            state_r <= LD_WAIT;
          end
        end
        LD_WAIT: begin
          if (mem_rvalid) begin
            if (last_row_s) begin
              state_r <= DONE;
            end else begin
              row_r   <= row_r + 2'd1;
              state_r <= LD_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            if (last_row_s) begin
              state_r <= DONE;
            end else begin
              row_r <= row_r + 2'd1;
            end
          end
        end
        MOPA_RUN: begin
          if (cnt_r == 4'd0) begin
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          row_r   <= 2'd0;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // Output decode: everything is zero outside the state that owns it.
  always_comb begin
    op_ready         = 1'b0;
    busy_stall       = accept_s;
    done             = 1'b0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = 32'd0;
    mem_wdata        = 32'd0;
    r_matrix_index   = 2'd0;
    w_matrix_en      = 1'b0;
    w_matrix_index   = 2'd0;
    w_matrix_data    = 32'd0;
    mopa_start       = 1'b0;
    w_matrix_en_mopa = 1'b0;
    case (state_r)
      IDLE: begin
        op_ready   = 1'b1;
        mopa_start = accept_s && (op_code == OP_MOPA);
      end
      LD_REQ: begin
        busy_stall = 1'b1;
        mem_req    = 1'b1;
        mem_addr   = addr_s;
      end
      LD_WAIT: begin
        busy_stall = 1'b1;
        // Only a load in flight may write a line from returned data.
        if (mem_rvalid && (code_r == OP_LOAD)) begin
          w_matrix_en    = 1'b1;
          w_matrix_index = row_r;
          w_matrix_data  = mem_rdata;
        end else begin
          w_matrix_en    = 1'b0;
        end
      end
      ST_REQ: begin
        busy_stall     = 1'b1;
        r_matrix_index = row_r;
        mem_req        = 1'b1;
        mem_we         = 1'b1;
        mem_addr       = addr_s;
        mem_wdata      = r_matrix_line;
      end
      MOPA_RUN: begin
        busy_stall       = 1'b1;
        w_matrix_en_mopa = (cnt_r == 4'd0);
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy_stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_matrix_seq.sv
// Directed cycle-by-cycle bench for matrix_seq with MOPA_LAT=3; inputs are set
// just after each rising edge and outputs are checked shortly after.
module tb_matrix_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] op_base;
  logic        op_ready;
  logic        busy_stall;
  logic        done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  r_matrix_index;
  logic [31:0] r_matrix_line;
  logic        w_matrix_en;
  logic [1:0]  w_matrix_index;
  logic [31:0] w_matrix_data;
  logic        mopa_start;
  logic        w_matrix_en_mopa;

  logic [31:0] mf [4];
  int n_tests = 0;
  int n_fail  = 0;

  matrix_seq #(.MOPA_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_code(op_code), .op_base(op_base),
    .op_ready(op_ready), .busy_stall(busy_stall), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .r_matrix_index(r_matrix_index), .r_matrix_line(r_matrix_line),
    .w_matrix_en(w_matrix_en), .w_matrix_index(w_matrix_index), .w_matrix_data(w_matrix_data),
    .mopa_start(mopa_start), .w_matrix_en_mopa(w_matrix_en_mopa)
  );

  always #5 clk = ~clk;

  assign r_matrix_line = mf[r_matrix_index];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, "_op_ready"}, 32'(op_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy_stall), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_r_idx"}, 32'(r_matrix_index), 32'd0);
    check({tag, "_w_en"}, 32'(w_matrix_en), 32'd0);
    check({tag, "_w_idx"}, 32'(w_matrix_index), 32'd0);
    check({tag, "_w_data"}, w_matrix_data, 32'd0);
    check({tag, "_mopa_start"}, 32'(mopa_start), 32'd0);
    check({tag, "_en_mopa"}, 32'(w_matrix_en_mopa), 32'd0);
  endtask

  // Accept cycle, then rows 0..last_row with immediate gnt and rvalid one cycle later.
  task automatic load_rows(input string tag, input logic [31:0] base,
                           input logic [31:0] rd0, input int last_row);
    op_valid = 1'b1; op_code = 2'b01; op_base = base; #1;
    check($sformatf("%s_acc_stall", tag), 32'(busy_stall), 32'd1);
    check($sformatf("%s_acc_ready", tag), 32'(op_ready), 32'd1);
    check($sformatf("%s_acc_req", tag), 32'(mem_req), 32'd0);
    step();
    for (int r = 0; r <= last_row; r++) begin
      mem_gnt = 1'b1; mem_rvalid = 1'b0; #1;
      check($sformatf("%s_req%0d", tag, r), 32'(mem_req), 32'd1);
      check($sformatf("%s_we%0d", tag, r), 32'(mem_we), 32'd0);
      check($sformatf("%s_addr%0d", tag, r), mem_addr, base + 32'(4 * r));
      check($sformatf("%s_rstall%0d", tag, r), 32'(busy_stall), 32'd1);
      check($sformatf("%s_rwen%0d", tag, r), 32'(w_matrix_en), 32'd0);
      step();
      mem_gnt = 1'b0;
      if (r < last_row) begin
        mem_rvalid = 1'b1; mem_rdata = rd0 + 32'(r); #1;
        check($sformatf("%s_wen%0d", tag, r), 32'(w_matrix_en), 32'd1);
        check($sformatf("%s_widx%0d", tag, r), 32'(w_matrix_index), 32'(r));
        check($sformatf("%s_wdata%0d", tag, r), w_matrix_data, rd0 + 32'(r));
        check($sformatf("%s_wreq%0d", tag, r), 32'(mem_req), 32'd0);
        check($sformatf("%s_wstall%0d", tag, r), 32'(busy_stall), 32'd1);
        step();
      end
    end
  endtask

  task automatic run_load(input string tag, input logic [31:0] base, input logic [31:0] rd0);
    load_rows(tag, base, rd0, 3);
    mem_rvalid = 1'b1; mem_rdata = rd0 + 32'd3; #1;
    check({tag, "_wen3"}, 32'(w_matrix_en), 32'd1);
    check({tag, "_widx3"}, 32'(w_matrix_index), 32'd3);
    check({tag, "_wdata3"}, w_matrix_data, rd0 + 32'd3);
    check({tag, "_stall9"}, 32'(busy_stall), 32'd1);
    step();
    mem_rvalid = 1'b0; #1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_stall"}, 32'(busy_stall), 32'd0);
    check({tag, "_done_ready"}, 32'(op_ready), 32'd0);
    check({tag, "_done_wen"}, 32'(w_matrix_en), 32'd0);
    step();
    op_valid = 1'b0; op_code = 2'b00;
  endtask

  initial begin
    rst = 1'b0; op_valid = 1'b0; op_code = 2'b00; op_base = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    mf[0] = 32'h11; mf[1] = 32'h22; mf[2] = 32'h33; mf[3] = 32'h44;
    step(); step();
    rst = 1'b1; #1;
    chk_quiet("reset");

    // MLOAD4 at 0x100, then MSTORE4 accepted right after its DONE cycle.
    run_load("ld100", 32'h0000_0100, 32'h0000_00A0);

    op_valid = 1'b1; op_code = 2'b10; op_base = 32'h0000_0200; #1;
    check("st_acc_ready", 32'(op_ready), 32'd1);
    check("st_acc_stall", 32'(busy_stall), 32'd1);
    step();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k <= ((r == 1) ? 2 : 0); k++) begin
        mem_gnt = (r != 1) || (k == 2); #1;
        check($sformatf("st_req%0d_%0d", r, k), 32'(mem_req), 32'd1);
        check($sformatf("st_we%0d_%0d", r, k), 32'(mem_we), 32'd1);
        check($sformatf("st_addr%0d_%0d", r, k), mem_addr, 32'h0000_0200 + 32'(4 * r));
        check($sformatf("st_wdata%0d_%0d", r, k), mem_wdata, mf[r]);
        check($sformatf("st_ridx%0d_%0d", r, k), 32'(r_matrix_index), 32'(r));
        check($sformatf("st_stall%0d_%0d", r, k), 32'(busy_stall), 32'd1);
        step();
      end
    end
    mem_gnt = 1'b0; #1;
    check("st_done", 32'(done), 32'd1);
    check("st_done_req", 32'(mem_req), 32'd0);
    check("st_done_stall", 32'(busy_stall), 32'd0);
    step();
    op_valid = 1'b0; op_code = 2'b00; #1;
    chk_quiet("st_idle");

    // MOPA with MOPA_LAT=3: start cycle 1, commit cycle 4, done cycle 5.
    op_valid = 1'b1; op_code = 2'b11; op_base = 32'h0; #1;
    check("mopa_start_c1", 32'(mopa_start), 32'd1);
    check("mopa_stall_c1", 32'(busy_stall), 32'd1);
    check("mopa_req_c1", 32'(mem_req), 32'd0);
    step();
    for (int c = 2; c <= 4; c++) begin
      #1;
      check($sformatf("mopa_start_c%0d", c), 32'(mopa_start), 32'd0);
      check($sformatf("mopa_en_c%0d", c), 32'(w_matrix_en_mopa), (c == 4) ? 32'd1 : 32'd0);
      check($sformatf("mopa_req_c%0d", c), 32'(mem_req), 32'd0);
      check($sformatf("mopa_stall_c%0d", c), 32'(busy_stall), 32'd1);
      check($sformatf("mopa_done_c%0d", c), 32'(done), 32'd0);
      step();
    end
    check("mopa_done_c5", 32'(done), 32'd1);
    check("mopa_en_c5", 32'(w_matrix_en_mopa), 32'd0);
    check("mopa_req_c5", 32'(mem_req), 32'd0);
    step();
    op_valid = 1'b0; op_code = 2'b00; #1;
    chk_quiet("mopa_idle");

    // Address wrap past 2^32.
    load_rows("wrap", 32'hFFFF_FFF8, 32'h0000_0050, 0);
    mem_rvalid = 1'b0; #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h50; #1;
    check("wrap_wen0", 32'(w_matrix_en), 32'd1);
    step();
    mem_rvalid = 1'b0;
    for (int r = 1; r < 4; r++) begin
      mem_gnt = 1'b1; #1;
      check($sformatf("wrap_addr%0d", r), mem_addr,
            (r == 1) ? 32'hFFFF_FFFC : ((r == 2) ? 32'h0000_0000 : 32'h0000_0004));
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h50 + 32'(r);
      step();
      mem_rvalid = 1'b0;
    end
    #1;
    check("wrap_done", 32'(done), 32'd1);
    step();
    op_valid = 1'b0; op_code = 2'b00; #1;
    chk_quiet("wrap_idle");

    // Reset in LD_WAIT of row 2; a late rvalid must not write.
    load_rows("rld", 32'h0000_0300, 32'h0000_00C0, 2);
    op_valid = 1'b0; op_code = 2'b00; rst = 1'b0; #1;
    check("rld_wait_wen", 32'(w_matrix_en), 32'd0);
    step();
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk_quiet("rld_after");
    step();
    mem_rvalid = 1'b0; #1;
    chk_quiet("rld_after2");

    // op_code 00 is ignored; rvalid in IDLE does not write.
    op_valid = 1'b1; op_code = 2'b00; op_base = 32'h400; mem_rvalid = 1'b1; #1;
    chk_quiet("nop_c1");
    step();
    #1;
    chk_quiet("nop_c2");
    op_valid = 1'b0; mem_rvalid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_seq.md
# matrix_seq

Multi-cycle sequencer for the 4-line x 32-bit matrix register file. It accepts one matrix block operation per instruction from decode: load-4, store-4 or outer-product accumulate (MOPA). It drives the matrix file's write ports and a single-outstanding memory request interface, and holds the pipeline stalled until the operation retires. It sits beside the decode stage; `busy_stall` ORs into the pipeline's `ctrl_stall`.

## Interface
- `MOPA_LAT`, default 2: cycles the external MOPA compute unit needs from `mopa_start` to valid result (legal range 1..15).
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset, synchronous, active-low.
- `op_valid` in 1: decode presents a matrix block op.
- `op_code` in 2: 00 none/ignored, 01 MLOAD4, 10 MSTORE4, 11 MOPA.
- `op_base` in 32: byte base address (rs1 value) for MLOAD4/MSTORE4.
- `op_ready` out 1: high only in IDLE.
- `busy_stall` out 1: stall request to the pipeline.
- `done` out 1: one-cycle retire pulse.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32: memory request.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1, `mem_rdata` in 32: load return.
- `r_matrix_index` out 2, `r_matrix_line` in 32: combinational matrix-file read port, used by stores.
- `w_matrix_en` out 1, `w_matrix_index` out 2, `w_matrix_data` out 32: single-line write port.
- `mopa_start` out 1: one-cycle start pulse to the MOPA compute unit.
- `w_matrix_en_mopa` out 1: commit the 4-line MOPA result.

## Operation
- States: IDLE, LD_REQ, LD_WAIT, ST_REQ, MOPA_RUN, DONE. Row counter `row` is 2 bits; MOPA counter is 4 bits.
- IDLE: when `op_valid` is high and `op_code` is nonzero, latch `op_base` and `op_code` and set `row`=0.
  - Next state: 01 goes to LD_REQ, 10 goes to ST_REQ, 11 goes to MOPA_RUN.
  - On the MOPA transition, pulse `mopa_start` in that same cycle and load the counter with `MOPA_LAT`-1.
  - `op_code` 00 is ignored.
- Address: `mem_addr` = base + {row,2'b00}, modulo 2^32 (wraps, no error).
- LD_REQ: drive `mem_req`=1 and `mem_we`=0 until `mem_gnt`, then go to LD_WAIT.
- LD_WAIT: on `mem_rvalid`, assert `w_matrix_en`=1 with `w_matrix_index`=row and `w_matrix_data`=`mem_rdata` for that cycle.
  - If row==3, go to DONE; otherwise increment row and go to LD_REQ.
- ST_REQ: drive `r_matrix_index`=row, `mem_wdata`=`r_matrix_line`, `mem_req`=1, `mem_we`=1.
  - On `mem_gnt`: if row==3, go to DONE; otherwise increment row and stay in ST_REQ.
- MOPA_RUN: decrement the counter each cycle. In the cycle the counter is 0, assert `w_matrix_en_mopa`=1 and go to DONE.
- DONE: `done`=1 and `op_valid` is ignored; always return to IDLE.
- `busy_stall` = (IDLE & `op_valid` & `op_code`!=0) | (state not in {IDLE, DONE}).
  - The stall is combinational from `op_valid` in IDLE, so the instruction is held in decode from its first cycle.
  - The stall drops in DONE, so the instruction advances exactly once.
- Outside their active states, `mem_req`, `w_matrix_en`, `w_matrix_en_mopa`, `mopa_start` and `done` are 0, and the data/address outputs are 0.
- `mem_rvalid` outside LD_WAIT is ignored. `mem_gnt` while `mem_req` is 0 is ignored.

## Timing
- Reset (`rst`=0 at a rising edge):
  - State returns to IDLE, `row`=0, counters cleared, latched op cleared.
  - All outputs are 0 except `op_ready`=1.
  - An operation interrupted mid-way is abandoned: no further `mem_req` or matrix write, and partially written lines remain.
- Memory contract: `mem_rvalid` arrives no earlier than the cycle after `mem_gnt`. At most one request is outstanding.
- Best-case latency, counted from the accept cycle to the `done` cycle inclusive (gnt in the same cycle, rvalid the next cycle):
  - MLOAD4: 10 cycles.
  - MSTORE4: 6 cycles.
  - MOPA: `MOPA_LAT`+2 cycles.
- Stalls: each cycle `mem_gnt` is low extends REQ by one cycle, with request outputs held stable. Each extra cycle without rvalid extends LD_WAIT by one cycle.
- Back-to-back: a new op can be accepted in the cycle after DONE.

## Test plan
- MLOAD4, base 0x100, gnt immediate, rvalid +1, returning rdata 0xA0..0xA3:
  - Addresses 0x100, 0x104, 0x108, 0x10C.
  - Four `w_matrix_en` pulses, index 0..3, data 0xA0..0xA3.
  - `done` in cycle 10; `busy_stall` high in cycles 1-9.
- MSTORE4, base 0x200, lines 0x11, 0x22, 0x33, 0x44, `mem_gnt` low for 2 cycles on row 1:
  - Four writes (`mem_we`=1) with matching addresses and data; row 1's request held 3 cycles.
  - `done` in cycle 8.
- MOPA with `MOPA_LAT`=3:
  - `mopa_start` in cycle 1, `w_matrix_en_mopa` in cycle 4, `done` in cycle 5.
  - No `mem_req` throughout.
- MLOAD4, base 0xFFFFFFF8: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- `rst`=0 during LD_WAIT of row 2:
  - Next cycle all outputs are 0 and `op_ready`=1.
  - A late `mem_rvalid` causes no `w_matrix_en`.
- `op_code`=00 with `op_valid`=1: no stall, no state change. `mem_rvalid` asserted in IDLE: no write.
